hazard_stall_unit: RTL

Decode-stage stall controller for the 5-stage RISC-V pipeline. It sits directly upstream of the forwarding unit. It inserts bubbles into ID/EX only when forwarding cannot deliver an operand in time: load-use, branch/jalr after a load, and jalr after an in-flight ALU write. It also freezes the whole front end during cache/memory stalls. A registered bubble counter makes the stall length deterministic instead of relying on combinational re-detection.

---
 rtl/hazard_stall_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - decode-stage bubble/freeze controller with a registered bubble counter
// Optional perf counters are enabled by defining HAZARD_PERF_EN.
module hazard_stall_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic       branch,
    input  logic       jalr,
    input  logic [4:0] ID_EX_rd,
    input  logic       ID_EX_regwrite,
    input  logic       ID_EX_memread,
    input  logic [4:0] EX_MEM_rd,
    input  logic       EX_MEM_regwrite,
    input  logic       EX_MEM_memread,
    input  logic       mem_stall,
    input  logic       kill,
    output logic       pc_write,
    output logic       IF_ID_write,
    output logic       ID_EX_write,
    output logic       ID_EX_bubble,
    output logic       hazard_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_bubble_cnt,
    output logic [31:0] perf_memstall_cnt
`endif
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_STALL = 1'b1;

    logic [0:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       m_e1, m_e2, m_m1, m_m2;
    logic [1:0] need_n;

    always_comb begin
        m_e1 = (ID_EX_rd  != 5'd0) && (ID_EX_rd  == rs1) && use_rs1;
        m_e2 = (ID_EX_rd  != 5'd0) && (ID_EX_rd  == rs2) && use_rs2;
        m_m1 = (EX_MEM_rd != 5'd0) && (EX_MEM_rd == rs1) && use_rs1;
        m_m2 = (EX_MEM_rd != 5'd0) && (EX_MEM_rd == rs2) && use_rs2;

        // One-bubble rules first, two-bubble rules override to yield the maximum.
        need_n = 2'd0;
        if (ID_EX_memread && (m_e1 || m_e2) && !branch && !jalr) need_n = 2'd1;
        if (branch && EX_MEM_memread && (m_m1 || m_m2))          need_n = 2'd1;
        if (jalr && ID_EX_regwrite && !ID_EX_memread && m_e1)     need_n = 2'd1;
        if (jalr && EX_MEM_memread && m_m1)                       need_n = 2'd1;
        if (branch && ID_EX_memread && (m_e1 || m_e2))            need_n = 2'd2;
        if (jalr && ID_EX_memread && m_e1)                        need_n = 2'd2;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_write  = 1'b1;
        ID_EX_bubble = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            state_d      = S_IDLE;
            cnt_d        = 2'd0;
        end else if (mem_stall) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_write = 1'b0;
        end else if (kill) begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
        end else if (state_q == S_STALL) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            cnt_d        = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
            if (cnt_q <= 2'd1) state_d = S_IDLE;
        end else if (need_n != 2'd0) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            cnt_d        = need_n - 2'd1;
            state_d      = (need_n > 2'd1) ? S_STALL : S_IDLE;
        end
        hazard_busy = !rst && (state_q == S_STALL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_bubble_q, perf_bubble_d;
    logic [31:0] perf_memstall_q, perf_memstall_d;

    always_comb begin
        perf_bubble_d   = perf_bubble_q;
        perf_memstall_d = perf_memstall_q;
        if (ID_EX_bubble && perf_bubble_q != 32'hFFFF_FFFF)
            perf_bubble_d = perf_bubble_q + 32'd1;
        if (mem_stall && perf_memstall_q != 32'hFFFF_FFFF)
            perf_memstall_d = perf_memstall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bubble_q   <= 32'd0;
            perf_memstall_q <= 32'd0;
        end else begin
            perf_bubble_q   <= perf_bubble_d;
            perf_memstall_q <= perf_memstall_d;
        end
    end

    assign perf_bubble_cnt   = perf_bubble_q;
    assign perf_memstall_cnt = perf_memstall_q;
`endif

endmodule
